// File: rtl/cv32e40p_ft_pkg.sv
// rtl/cv32e40p_ft_pkg.sv - shared types for the fault-tolerant cv32e40p fault tracker
package cv32e40p_ft_pkg;

    localparam int N_SUB_UNITS = 9;

    typedef enum logic [3:0] {
        SUB_SHIFT  = 4'd0,
        SUB_LOGIC  = 4'd1,
        SUB_BITMAN = 4'd2,
        SUB_BITCNT = 4'd3,
        SUB_SHUF   = 4'd4,
        SUB_CMP    = 4'd5,
        SUB_ABS    = 4'd6,
        SUB_MINMAX = 4'd7,
        SUB_DIV    = 4'd8
    } sub_unit_e;

    localparam logic [3:0] SUB_NONE = 4'(N_SUB_UNITS);

    typedef enum logic [6:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SRA, ALU_SRL, ALU_ROR, ALU_SLL,
        ALU_BEXT, ALU_BEXTU, ALU_BINS, ALU_BCLR, ALU_BSET, ALU_BREV,
        ALU_FF1, ALU_FL1, ALU_CNT, ALU_CLB,
        ALU_SHUF, ALU_SHUF2, ALU_PCKLO, ALU_PCKHI, ALU_INS, ALU_EXT, ALU_EXTS,
        ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
        ALU_EQ, ALU_NE, ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU,
        ALU_ABS, ALU_CLIP, ALU_CLIPU,
        ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_opcode_e;

    // Adders are not tracked: they are duplicated elsewhere and have no steerable spare.
    function automatic logic [3:0] alu_op_to_sub(alu_opcode_e op);
        logic [3:0] sub;
        sub = SUB_NONE;
        case (op)
            ALU_SRA, ALU_SRL, ALU_ROR, ALU_SLL:                        sub = SUB_SHIFT;
            ALU_XOR, ALU_OR, ALU_AND:                                  sub = SUB_LOGIC;
            ALU_BEXT, ALU_BEXTU, ALU_BINS, ALU_BCLR, ALU_BSET,
            ALU_BREV:                                                  sub = SUB_BITMAN;
            ALU_FF1, ALU_FL1, ALU_CNT, ALU_CLB:                        sub = SUB_BITCNT;
            ALU_SHUF, ALU_SHUF2, ALU_PCKLO, ALU_PCKHI, ALU_INS,
            ALU_EXT, ALU_EXTS:                                         sub = SUB_SHUF;
            ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU, ALU_GTS, ALU_GTU,
            ALU_GES, ALU_GEU, ALU_EQ, ALU_NE, ALU_SLTS, ALU_SLTU,
            ALU_SLETS, ALU_SLETU:                                      sub = SUB_CMP;
            ALU_ABS, ALU_CLIP, ALU_CLIPU:                              sub = SUB_ABS;
            ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU:                      sub = SUB_MINMAX;
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:                      sub = SUB_DIV;
            default:                                                   sub = SUB_NONE;
        endcase
        return sub;
    endfunction

endpackage

// File: rtl/cv32e40p_ft_leaky_counter.sv
// rtl/cv32e40p_ft_leaky_counter.sv - one saturating leaky-bucket counter with sticky fault flag
module cv32e40p_ft_leaky_counter
    import cv32e40p_ft_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int INC       = 1,
    parameter int DEC       = 2,
    parameter int THRESHOLD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic upd,
    input  logic err,
    input  logic clr,
    output logic flag,
    output logic set_pulse
);

    localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'((1 << CNT_W) - 1);
    localparam logic [CNT_W:0] INC_W = (CNT_W+1)'(INC);
    localparam logic [CNT_W:0] DEC_W = (CNT_W+1)'(DEC);
    localparam logic [CNT_W:0] THR_W = (CNT_W+1)'(THRESHOLD);

    generate
        if (THRESHOLD < 1 || THRESHOLD > (1 << CNT_W) - 1) begin : g_bad_threshold
            $error("cv32e40p_ft_leaky_counter: THRESHOLD out of range 1..2^CNT_W-1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q;
    logic [CNT_W:0]   sum;
    logic             hit;

    always_comb begin
        sum = {1'b0, cnt_q} + INC_W;
        if (err) begin
            cnt_d = (sum > MAX_W) ? MAX_W[CNT_W-1:0] : sum[CNT_W-1:0];
        end else begin
            cnt_d = ({1'b0, cnt_q} > DEC_W) ? cnt_q - DEC_W[CNT_W-1:0] : '0;
        end
        hit = ({1'b0, cnt_d} >= THR_W);
    end

    // A flagged pair is frozen, so only unflagged updates can produce a new event.
    assign set_pulse = upd & ~flag_q & ~clr & hit;
    assign flag      = flag_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (upd && !flag_q) begin
            if (hit) begin
                cnt_q  <= '0;
                flag_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_fu_fault_tracker_ft.sv
// rtl/cv32e40p_fu_fault_tracker_ft.sv - per-(channel, sub-unit) permanent-fault tracker
module cv32e40p_fu_fault_tracker_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int N_SUB     = 9,
    parameter int CNT_W     = 8,
    parameter int INC       = 1,
    parameter int DEC       = 2,
    parameter int THRESHOLD = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH-1:0]              valid_i,
    input  logic [$clog2(N_SUB+1)-1:0]   sub_sel_i,
    input  logic [N_CH-1:0]              err_i,
    input  logic                         clr_i,
    output logic [N_CH*N_SUB-1:0]        faulty_o,
    output logic [N_CH-1:0]              ch_faulty_o,
    output logic [N_CH-1:0]              fault_evt_o
);

    localparam int SEL_W = $clog2(N_SUB+1);

    logic [N_CH*N_SUB-1:0] flag;
    logic [N_CH*N_SUB-1:0] set_pulse;
    logic [N_CH-1:0]       ch_faulty_d, ch_faulty_q;
    logic [N_CH-1:0]       evt_d, evt_q;

    // Flag bit for (c, s) lives at c*N_SUB + s; a selector >= N_SUB matches nothing.
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            for (genvar s = 0; s < N_SUB; s++) begin : g_sub
                logic upd;
                assign upd = valid_i[c] && (sub_sel_i == SEL_W'(s));

                cv32e40p_ft_leaky_counter #(
                    .CNT_W     (CNT_W),
                    .INC       (INC),
                    .DEC       (DEC),
                    .THRESHOLD (THRESHOLD)
                ) u_cnt (
                    .clk       (clk),
                    .rst       (rst),
                    .upd       (upd),
                    .err       (err_i[c]),
                    .clr       (clr_i),
                    .flag      (flag[c*N_SUB + s]),
                    .set_pulse (set_pulse[c*N_SUB + s])
                );
            end
        end
    endgenerate

    // Summaries are built from next-state flags so they line up with faulty_o.
    always_comb begin
        evt_d       = '0;
        ch_faulty_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            evt_d[c]       = |set_pulse[c*N_SUB +: N_SUB];
            ch_faulty_d[c] = !clr_i && |(flag[c*N_SUB +: N_SUB] | set_pulse[c*N_SUB +: N_SUB]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q       <= '0;
            ch_faulty_q <= '0;
        end else begin
            evt_q       <= evt_d;
            ch_faulty_q <= ch_faulty_d;
        end
    end

    assign faulty_o    = flag;
    assign ch_faulty_o = ch_faulty_q;
    assign fault_evt_o = evt_q;

endmodule

// File: tb/tb_cv32e40p_fu_fault_tracker_ft.sv
// tb/tb_cv32e40p_fu_fault_tracker_ft.sv - directed self-checking bench for the fault tracker
module tb_cv32e40p_fu_fault_tracker_ft;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid, err;
    logic [3:0]  sel;
    logic        clr;
    logic [35:0] faulty;
    logic [3:0]  ch_faulty, evt;

    logic [3:0]  s_valid, s_err, s_sel;
    logic        s_clr;
    logic [35:0] s_faulty;
    logic [3:0]  s_ch_faulty, s_evt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_fu_fault_tracker_ft dut (
        .clk(clk), .rst(rst), .valid_i(valid), .sub_sel_i(sel), .err_i(err), .clr_i(clr),
        .faulty_o(faulty), .ch_faulty_o(ch_faulty), .fault_evt_o(evt)
    );

    cv32e40p_fu_fault_tracker_ft #(.CNT_W(4), .INC(4), .DEC(2), .THRESHOLD(15)) dut_sat (
        .clk(clk), .rst(rst), .valid_i(s_valid), .sub_sel_i(s_sel), .err_i(s_err), .clr_i(s_clr),
        .faulty_o(s_faulty), .ch_faulty_o(s_ch_faulty), .fault_evt_o(s_evt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e, input logic c);
        @(negedge clk);
        valid = v; sel = s; err = e; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic repeat_step(input int n, input logic [3:0] v, input logic [3:0] s, input logic [3:0] e);
        for (int i = 0; i < n; i++) step(v, s, e, 1'b0);
    endtask

    logic [35:0] exp_f;

    initial begin
        rst = 1'b1; valid = '0; sel = '0; err = '0; clr = 1'b0;
        s_valid = '0; s_sel = '0; s_err = '0; s_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk); rst = 1'b0;
        repeat_step(10, 4'b0000, 4'd0, 4'b0000);
        check("reset_faulty", 64'(faulty), 64'd0);
        check("reset_ch_faulty", 64'(ch_faulty), 64'd0);
        check("reset_evt", 64'(evt), 64'd0);
        check("reset_cnt_1_5", 64'(dut.g_ch[1].g_sub[5].u_cnt.cnt_q), 64'd0);

        // ch1, sub5: threshold crossing on the 100th error
        repeat_step(99, 4'b0010, 4'd5, 4'b0010);
        check("thr_cnt99", 64'(dut.g_ch[1].g_sub[5].u_cnt.cnt_q), 64'd99);
        check("thr_no_flag_99", 64'(faulty), 64'd0);
        check("thr_no_evt_99", 64'(evt), 64'd0);
        step(4'b0010, 4'd5, 4'b0010, 1'b0);
        exp_f = 36'd1 << 14;
        check("thr_flag", 64'(faulty), 64'(exp_f));
        check("thr_evt", 64'(evt), 64'b0010);
        check("thr_ch_faulty", 64'(ch_faulty), 64'b0010);
        check("thr_cnt_zero", 64'(dut.g_ch[1].g_sub[5].u_cnt.cnt_q), 64'd0);
        step(4'b0000, 4'd0, 4'b0000, 1'b0);
        check("thr_evt_one_cycle", 64'(evt), 64'd0);

        // ch0, sub0: leak back to zero, then 99 errors stay clear, 100th sets
        repeat_step(50, 4'b0001, 4'd0, 4'b0001);
        check("leak_cnt50", 64'(dut.g_ch[0].g_sub[0].u_cnt.cnt_q), 64'd50);
        repeat_step(30, 4'b0001, 4'd0, 4'b0000);
        check("leak_floor0", 64'(dut.g_ch[0].g_sub[0].u_cnt.cnt_q), 64'd0);
        repeat_step(99, 4'b0001, 4'd0, 4'b0001);
        check("leak_99_clear", 64'(faulty), 64'(exp_f));
        step(4'b0001, 4'd0, 4'b0001, 1'b0);
        exp_f = exp_f | 36'd1;
        check("leak_100_flag", 64'(faulty), 64'(exp_f));
        check("leak_evt", 64'(evt), 64'b0001);

        // ignore rules: out-of-range selector and err without valid
        repeat_step(5, 4'b1111, 4'd9, 4'b1111);
        check("ign_sel9_cnt", 64'(dut.g_ch[2].g_sub[3].u_cnt.cnt_q), 64'd0);
        check("ign_sel9_cnt_ch3s8", 64'(dut.g_ch[3].g_sub[8].u_cnt.cnt_q), 64'd0);
        repeat_step(5, 4'b0000, 4'd3, 4'b1111);
        check("ign_novalid_cnt", 64'(dut.g_ch[2].g_sub[3].u_cnt.cnt_q), 64'd0);
        check("ign_faulty", 64'(faulty), 64'(exp_f));
        check("ign_evt", 64'(evt), 64'd0);

        // ch2 and ch3 cross together on sub3
        repeat_step(99, 4'b1100, 4'd3, 4'b1100);
        check("dual_cnt_ch2", 64'(dut.g_ch[2].g_sub[3].u_cnt.cnt_q), 64'd99);
        step(4'b1100, 4'd3, 4'b1100, 1'b0);
        exp_f = exp_f | (36'd1 << 21) | (36'd1 << 30);
        check("dual_flags", 64'(faulty), 64'(exp_f));
        check("dual_evt", 64'(evt), 64'b1100);
        check("dual_ch_faulty", 64'(ch_faulty), 64'b1111);

        // sticky: flagged pair ignores further errors
        repeat_step(3, 4'b0010, 4'd5, 4'b0010);
        check("sticky_cnt", 64'(dut.g_ch[1].g_sub[5].u_cnt.cnt_q), 64'd0);
        check("sticky_evt", 64'(evt), 64'd0);
        check("sticky_faulty", 64'(faulty), 64'(exp_f));

        // clear in the same cycle as an error: all zero, no pulse
        repeat_step(10, 4'b1000, 4'd7, 4'b1000);
        check("pre_clr_cnt", 64'(dut.g_ch[3].g_sub[7].u_cnt.cnt_q), 64'd10);
        step(4'b1000, 4'd7, 4'b1000, 1'b1);
        check("clr_faulty", 64'(faulty), 64'd0);
        check("clr_ch_faulty", 64'(ch_faulty), 64'd0);
        check("clr_evt", 64'(evt), 64'd0);
        check("clr_cnt", 64'(dut.g_ch[3].g_sub[7].u_cnt.cnt_q), 64'd0);
        repeat_step(100, 4'b0010, 4'd5, 4'b0010);
        check("recross_faulty", 64'(faulty), 64'(36'd1 << 14));
        check("recross_evt", 64'(evt), 64'b0010);

        // reset mid-sequence discards counts
        repeat_step(20, 4'b0001, 4'd2, 4'b0001);
        @(negedge clk); rst = 1'b1; valid = '0; err = '0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        check("rst_mid_cnt", 64'(dut.g_ch[0].g_sub[2].u_cnt.cnt_q), 64'd0);
        check("rst_mid_faulty", 64'(faulty), 64'd0);

        // saturation instance: 4, 8, 12, then clamp to 15 sets the flag
        @(negedge clk); s_valid = 4'b0001; s_sel = 4'd4; s_err = 4'b0001;
        @(posedge clk); #1;
        check("sat_cnt4", 64'(dut_sat.g_ch[0].g_sub[4].u_cnt.cnt_q), 64'd4);
        @(posedge clk); #1;
        check("sat_cnt8", 64'(dut_sat.g_ch[0].g_sub[4].u_cnt.cnt_q), 64'd8);
        @(posedge clk); #1;
        check("sat_cnt12", 64'(dut_sat.g_ch[0].g_sub[4].u_cnt.cnt_q), 64'd12);
        check("sat_no_flag", 64'(s_faulty), 64'd0);
        @(posedge clk); #1;
        check("sat_flag", 64'(s_faulty), 64'(36'd1 << 4));
        check("sat_evt", 64'(s_evt), 64'b0001);
        check("sat_cnt0", 64'(dut_sat.g_ch[0].g_sub[4].u_cnt.cnt_q), 64'd0);
        @(negedge clk); s_valid = '0; s_err = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
